// File: rtl/addsub_byte_sequencer_if.sv
// Request/response bus of the multi-byte add/subtract sequencer.
`timescale 1ns/1ps
interface addsub_byte_sequencer_if #(
    parameter int unsigned NBYTES = 4,
    parameter int unsigned LENW   = $clog2(NBYTES) + 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   in_a;
    logic [8*NBYTES-1:0]   in_b;
    logic                  in_sub;
    logic [LENW-1:0]       in_len;

    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   out_sum;
    logic                  out_c;
    logic                  out_v;
    logic                  out_z;

    // Requester / result consumer side
    modport master (
        output in_valid, in_a, in_b, in_sub, in_len, out_ready,
        input  in_ready, out_valid, out_sum, out_c, out_v, out_z
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_len, out_ready,
        output in_ready, out_valid, out_sum, out_c, out_v, out_z
    );
endinterface

// File: rtl/addsub_byte_sequencer.sv
// Multi-byte add/subtract sequencer: drives an external 8-bit adder one byte
// per cycle (LSB first), chains the carry and returns the result with C/V/Z.
`timescale 1ns/1ps
module addsub_byte_sequencer #(
    parameter int unsigned NBYTES = 4,
    parameter int unsigned LENW   = $clog2(NBYTES) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    addsub_byte_sequencer_if.slave   bus,
    output logic [7:0]               add_a,
    output logic [7:0]               add_b,
    output logic                     add_ci,
    input  logic [7:0]               add_s,
    input  logic                     add_co
);
    localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_nxt;

    logic [NBYTES-1:0][7:0]    a_q;
    logic [NBYTES-1:0][7:0]    b_q;
    logic [NBYTES-1:0][7:0]    sum_q;
    logic [NBYTES-1:0][7:0]    sum_nxt;
    logic [NBYTES-1:0][7:0]    b_in;
    logic [IDXW-1:0]           idx;
    logic [IDXW-1:0]           idx_inc;
    logic [LENW-1:0]           len_q;
    logic [LENW-1:0]           len_eff;

    logic                      in_ready_q;
    logic                      out_valid_q;
    logic                      out_c_q;
    logic                      out_v_q;
    logic                      out_z_q;

    logic                      accept;
    logic                      last;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_c     = out_c_q;
    assign bus.out_v     = out_v_q;
    assign bus.out_z     = out_z_q;

    // Request decode: effective length, B' operand, handshake and last-byte flags
    always_comb begin
        len_eff = bus.in_len;
        if ((bus.in_len == '0) || (bus.in_len > LENW'(NBYTES))) begin
            len_eff = LENW'(NBYTES);
        end
        b_in    = bus.in_sub ? ~bus.in_b : bus.in_b;
        accept  = in_ready_q && bus.in_valid && !flush;
        last    = (LENW'(idx) == (len_q - LENW'(1)));
        idx_inc = idx + IDXW'(1);
        sum_nxt = sum_q;
        sum_nxt[idx] = add_s;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (accept) state_nxt = RUN;
                RUN:     if (last) state_nxt = DONE;
                DONE:    if (out_valid_q && bus.out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Handshake outputs registered from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= (state_nxt == IDLE);
            out_valid_q <= (state_nxt == DONE);
        end
    end

    // Datapath: operand capture, byte stepping, result/flag capture, adder gating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx     <= '0;
            len_q   <= '0;
            out_c_q <= 1'b0;
            out_v_q <= 1'b0;
            out_z_q <= 1'b0;
            add_a   <= '0;
            add_b   <= '0;
            add_ci  <= 1'b0;
        end else if (flush) begin
            add_a   <= '0;
            add_b   <= '0;
            add_ci  <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.in_a;
            b_q     <= b_in;
            len_q   <= len_eff;
            idx     <= '0;
            sum_q   <= '0;
            add_a   <= bus.in_a[7:0];
            add_b   <= b_in[0];
            add_ci  <= bus.in_sub;
        end else if (state == RUN) begin
            sum_q <= sum_nxt;
            if (last) begin
                out_c_q <= add_co;
                out_v_q <= (add_a[7] == add_b[7]) && (add_s[7] != add_a[7]);
                out_z_q <= (sum_nxt == '0);
                add_a   <= '0;
                add_b   <= '0;
                add_ci  <= 1'b0;
            end else begin
                idx     <= idx_inc;
                add_a   <= a_q[idx_inc];
                add_b   <= b_q[idx_inc];
                add_ci  <= add_co;
            end
        end
    end
endmodule

// File: tb/tb_addsub_byte_sequencer.sv
// Randomized scoreboard bench for addsub_byte_sequencer with a behavioural 8-bit adder.
`timescale 1ns/1ps
module tb_addsub_byte_sequencer;
    localparam int unsigned NB = 4;
    localparam int unsigned LW = 3;

    typedef struct packed {
        logic [31:0] sum;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_ci;
    logic [7:0] add_s;
    logic       add_co;

    int   n_vec;
    int   n_err;
    bit   rand_ready;
    exp_t sb[$];

    addsub_byte_sequencer_if #(.NBYTES(NB)) bus ();

    addsub_byte_sequencer #(.NBYTES(NB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .bus    (bus),
        .add_a  (add_a),
        .add_b  (add_b),
        .add_ci (add_ci),
        .add_s  (add_s),
        .add_co (add_co)
    );

    // Behavioural 8-bit adder
    assign {add_co, add_s} = 9'(add_a) + 9'(add_b) + 9'(add_ci);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: A +/- B modulo 2^(8*len) with unsigned carry and signed overflow
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic [LW-1:0] len);
        int              l;
        longint unsigned mask, am, bm, s;
        bit              sa, sbit, ss;
        exp_t            e;
        l    = ((len == 0) || (len > NB)) ? NB : int'(len);
        mask = (64'd1 << (8 * l)) - 64'd1;
        am   = {32'd0, a} & mask;
        bm   = {32'd0, b} & mask;
        if (sub) begin
            s   = (am - bm) & mask;
            e.c = (am >= bm);
        end else begin
            s   = am + bm;
            e.c = (s > mask);
            s   = s & mask;
        end
        sa   = am[8*l-1];
        sbit = bm[8*l-1];
        ss   = s[8*l-1];
        e.v  = sub ? ((sa != sbit) && (ss != sa)) : ((sa == sbit) && (ss != sa));
        e.sum = 32'(s);
        e.z  = (s == 0);
        return e;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    // Result monitor: pop expected entry on every output handshake
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got sum %h with empty scoreboard, expected no out_valid", bus.out_sum);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 64'({bus.out_sum, bus.out_c, bus.out_v, bus.out_z}), 64'(e));
            end
        end
    end

    // Adder-port monitor: operand bytes, carry chaining, and gating outside RUN
    bit          acc_prev;
    bit          in_run;
    int          run_i;
    int          run_len;
    logic [31:0] ra, rb, pa, pb;
    logic        rsub, psub, prev_co;
    int          plen;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_run   = 1'b0;
            acc_prev = 1'b0;
        end else begin
            if (acc_prev) begin
                in_run  = 1'b1;
                run_i   = 0;
                ra      = pa;
                rb      = pb;
                rsub    = psub;
                run_len = plen;
            end
            if (in_run) begin
                logic [7:0] ea, eb;
                logic       eci;
                ea  = 8'(ra >> (8 * run_i));
                eb  = 8'(rb >> (8 * run_i));
                eb  = rsub ? ~eb : eb;
                eci = (run_i == 0) ? rsub : prev_co;
                check("adder_run", 64'({add_a, add_b, add_ci}), 64'({ea, eb, eci}));
                prev_co = add_co;
                run_i++;
                if ((run_i == run_len) || flush) in_run = 1'b0;
            end else begin
                check("adder_gated", 64'({add_a, add_b, add_ci}), 64'(0));
            end
            acc_prev = bus.in_valid && bus.in_ready && !flush;
            pa   = bus.in_a;
            pb   = bus.in_b;
            psub = bus.in_sub;
            plen = ((bus.in_len == 0) || (bus.in_len > NB)) ? NB : int'(bus.in_len);
        end
    end

    // Random consumer backpressure during the regression
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Present one request and hold it until the accepting edge
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [LW-1:0] len);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_len   = len;
        while (!bus.in_ready && (w < 100)) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 100) check("issue_timeout", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = 32'($urandom);
        bus.in_b     = 32'($urandom);
    endtask

    // Wait until every expected result has been consumed
    task automatic drain(input int limit);
        int w;
        w = 0;
        while (((sb.size() != 0) || bus.out_valid) && (w < limit)) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain_pending", 64'(sb.size()), 64'(0));
    endtask

    task automatic check_reset_values(input string nm);
        check(nm, 64'({bus.in_ready, bus.out_valid, bus.out_sum, bus.out_c, bus.out_v, bus.out_z,
                       add_a, add_b, add_ci}),
              64'({1'b1, 1'b0, 32'd0, 3'b000, 8'd0, 8'd0, 1'b0}));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got time limit expired, expected run completion");
        $fatal(1);
    end

    initial begin
        int   n;
        exp_t snap;
        logic [31:0] a, b;
        logic        s;
        logic [LW-1:0] l;

        n_vec = 0;
        n_err = 0;
        rand_ready    = 1'b0;
        rst_n         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.in_len    = '0;
        bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset_state");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Add len=4, carry ripples across three byte boundaries; measure latency
        sb.push_back('{32'h0100_0000, 1'b0, 1'b0, 1'b0});
        issue(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 3'd4);
        n = 0;
        while (!bus.out_valid && (n < 50)) begin
            @(posedge clk);
            #1;
            n++;
        end
        // out_valid follows the accept edge by len further edges
        check("latency_len4", 64'(n), 64'(4));
        drain(50);

        // Subtracts, len=2
        sb.push_back('{32'h0000_FFFE, 1'b0, 1'b0, 1'b0});
        issue(32'h0000_0005, 32'h0000_0007, 1'b1, 3'd2);
        drain(50);
        sb.push_back('{32'h0000_7FFF, 1'b1, 1'b1, 1'b0});
        issue(32'h0000_8000, 32'h0000_0001, 1'b1, 3'd2);
        drain(50);

        // len=1 ignores upper bytes; len=0 means full width
        sb.push_back('{32'h0000_0000, 1'b1, 1'b1, 1'b1});
        issue(32'h1234_5680, 32'hAB00_0080, 1'b0, 3'd1);
        n = 0;
        while (!bus.out_valid && (n < 50)) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency_len1", 64'(n), 64'(1));
        drain(50);
        sb.push_back('{32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0});
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3'd0);
        drain(50);
        sb.push_back(model(32'h0000_0100, 32'h0000_0100, 1'b1, 3'd6));
        issue(32'h0000_0100, 32'h0000_0100, 1'b1, 3'd6);
        drain(50);

        // Backpressure in DONE, ignored request, then back-to-back accept
        bus.out_ready = 1'b0;
        sb.push_back(model(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 3'd3));
        issue(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 3'd3);
        n = 0;
        while (!bus.out_valid && (n < 50)) begin
            @(posedge clk);
            #1;
            n++;
        end
        snap = '{bus.out_sum, bus.out_c, bus.out_v, bus.out_z};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = (i == 3);
            bus.in_a     = 32'($urandom);
            bus.in_b     = 32'($urandom);
            check("backpressure_hold",
                  64'({bus.out_sum, bus.out_c, bus.out_v, bus.out_z, bus.out_valid, bus.in_ready}),
                  64'({snap, 1'b1, 1'b0}));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_to_idle", 64'({bus.in_ready, bus.out_valid}), 64'({1'b1, 1'b0}));
        sb.push_back(model(32'h0000_00FF, 32'h0000_0001, 1'b0, 3'd2));
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 3'd2);
        check("back_to_back_accepted", 64'(bus.in_ready), 64'(0));
        drain(50);

        // Flush during RUN at idx=2
        issue(32'h1111_1111, 32'h2222_2222, 1'b0, 3'd4);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_idle", 64'({bus.in_ready, bus.out_valid, add_a, add_b, add_ci}),
              64'({1'b1, 1'b0, 17'd0}));
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("flush_no_valid", 64'(bus.out_valid), 64'(0));
        end

        // Flush and request in the same IDLE cycle: flush wins
        bus.in_valid = 1'b1;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        check("flush_beats_request", 64'({bus.in_ready, add_a, add_b, add_ci}), 64'({1'b1, 17'd0}));
        @(posedge clk);
        #1;

        // Asynchronous reset mid-RUN
        issue(32'h1111_1111, 32'h2222_2222, 1'b1, 3'd4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset_mid_run");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random regression with random consumer backpressure
        rand_ready = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            a = rand_word();
            b = rand_word();
            s = 1'($urandom_range(0, 1));
            l = LW'($urandom_range(0, 7));
            sb.push_back(model(a, b, s, l));
            issue(a, b, s, l);
        end
        drain(2000);
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("final_idle", 64'({bus.in_ready, bus.out_valid}), 64'({1'b1, 1'b0}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
